store_rmw_unit: RTL and testbench
=================================

Name: store_rmw_unit

Overview:
- Parametrised sub-word store engine sitting between the datapath B register and data memory.
- Accepts word, halfword or byte stores at any byte address and selects the byte lane from the address offset.
- For sub-word stores, performs a read-modify-write over a ready-handshaked memory port: it reads the containing word, merges the store data into the addressed lane and writes the word back.
- Raises a misalignment flag for illegal halfword/word offsets instead of accessing memory.

Parameters:
- DATA_W, 32, memory word width in bits; multiple of 16, at least 16.
- ADDR_W, 32, byte-address width.
- LANES, DATA_W/8, derived byte lanes per word; not overridable.
- OFF_W, clog2(LANES), derived byte-offset width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request strobe; sampled only in IDLE.
- addr  in  ADDR_W  byte address of the store.
- store_data  in  DATA_W  store source (B register); the low 8/16/DATA_W bits are used.
- store_size  in  2  encoding: bit1=0 means full word; 10 means byte; 11 means halfword.
- mem_addr  out  ADDR_W  word-aligned address (addr with the low OFF_W bits cleared).
- mem_rd  out  1  read request; held until mem_ready.
- mem_wr  out  1  write request; held until mem_ready.
- mem_wdata  out  DATA_W  merged write word.
- mem_rdata  in  DATA_W  read data; valid in the cycle mem_ready=1 while mem_rd=1.
- mem_ready  in  1  memory accepted/completed the current request.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- misaligned  out  1  one-cycle pulse, coincident with done, on a rejected store.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. mem_rd, mem_wr, busy, done and misaligned are 0. mem_addr and mem_wdata are 0. Captured request registers are 0.
- Capture: in IDLE with start=1, the unit latches addr, store_data and store_size. start is ignored in every other state, with no queueing.
- Misalignment check at capture:
  - halfword requires offset[0]=0;
  - word requires offset=0;
  - byte is always legal.
- States:
  - IDLE -> ERR if misaligned; -> WRITE if word; -> READ otherwise.
  - READ: mem_rd=1 and mem_addr valid. On mem_ready: latch mem_rdata into the merge register and go to MERGE.
  - MERGE (one cycle): replace the addressed lane(s) of the merge register.
    - Byte: lane bits [8*off +: 8] = store_data[7:0].
    - Halfword: bits [8*off +: 16] = store_data[15:0].
    - All other bits are taken unchanged from read data.
    - Go to WRITE.
  - WRITE: mem_wr=1, with mem_wdata = merge register (sub-word) or store_data (word). On mem_ready: go to DONE.
  - DONE: done=1 for one cycle, busy=0 in this cycle; then go to IDLE.
  - ERR: done=1 and misaligned=1 for one cycle, with no memory request; then go to IDLE.
- busy is 1 in READ, MERGE and WRITE, and 0 in IDLE, DONE and ERR.
- Latency with mem_ready tied high, from the start cycle to the done pulse:
  - word: 2 cycles (WRITE, DONE);
  - sub-word: 4 cycles (READ, MERGE, WRITE, DONE);
  - misaligned: 1 cycle (ERR).
  - Each cycle of mem_ready=0 adds one wait cycle in READ or WRITE.
- mem_rd and mem_wr are never high together. Both are registered outputs with no combinational path from mem_ready.
- mem_addr, mem_wdata, mem_rd and mem_wr are held stable while waiting for mem_ready.
- mem_ready is ignored outside READ and WRITE.
- Reset mid-transaction drops the request immediately (mem_rd/mem_wr go to 0) and produces no done.
- start in the same cycle as DONE is ignored; the earliest new accept is the following IDLE cycle.
- Offset arithmetic uses only addr[OFF_W-1:0]. Upper address bits pass through to mem_addr unchanged, with no wrap logic.

Test Plan:
- Byte store: mem_rdata=0xAABBCCDD, addr=0x1002, store_size=10, store_data=0x12345677, ready tied high. Required: mem_rd with mem_addr=0x1000, then mem_wr with mem_wdata=0xAA77CCDD; done pulses 4 cycles after start.
- Halfword store: addr=0x2002, store_size=11, store_data=0x0000BEEF, mem_rdata=0x11223344. Required: mem_wdata=0xBEEF3344.
- Word store: addr=0x3000, store_size=00, store_data=0xCAFEF00D. Required: no mem_rd; mem_wr with mem_wdata=0xCAFEF00D at 0x3000; done 2 cycles after start.
- Misaligned stores: halfword at 0x1001 and word at 0x1002. Required: misaligned=1 with done, 1 cycle after start; mem_rd and mem_wr stay 0 throughout.
- Wait states: mem_ready held 0 for 3 cycles in READ and 2 cycles in WRITE. Required: request signals and address/data held stable; done arrives 5 cycles later than the zero-wait case.
- Abort and ignored start: reset driven low during WRITE gives mem_wr=0 immediately and no done; after release, a new byte store completes correctly. start pulsed while busy is ignored, giving exactly one done per accepted start.

Source files
------------

// File: rtl/store_rmw_unit.sv
// Sub-word store engine between the datapath B register and data memory.
// Word stores go straight to a memory write; byte/halfword stores read the
// containing word, merge the addressed lane(s) and write the word back.
// Illegal halfword/word offsets are rejected without touching memory.
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_start                 request strobe, sampled only when idle
//   i_addr, i_store_data    byte address and store source
//   i_store_size            0x: word, 10: byte, 11: halfword
//   o_mem_addr              word-aligned memory address
//   o_mem_rd, o_mem_wr      read / write requests, held until i_mem_ready
//   o_mem_wdata             merged write word
//   i_mem_rdata             read data, valid with i_mem_ready during a read
//   i_mem_ready             memory completed the current request
//   o_busy, o_done          in-flight flag and one-cycle completion pulse
//   o_misaligned            one-cycle reject pulse, coincident with o_done
module store_rmw_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_store_data,
    input  logic [1:0]        i_store_size,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd,
    output logic              o_mem_wr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_misaligned
);

    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(LANES);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StMerge,
        StWrite,
        StDone,
        StErr
    } state_e;

    state_e r_state;
    state_e w_state_next;

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_size;
    logic [DATA_W-1:0] r_merge;

    logic [OFF_W-1:0]  w_off_in;
    logic              w_reject;
    logic              w_accept;
    logic [OFF_W-1:0]  w_off;
    logic [OFF_W+2:0]  w_lsb;
    logic [DATA_W-1:0] w_merged;

    // Legality is judged on the incoming request so IDLE can branch to ERR directly.
    assign w_off_in = i_addr[OFF_W-1:0];
    assign w_reject = i_store_size[1] ? (i_store_size[0] & w_off_in[0])
                                      : (w_off_in != '0);
    assign w_accept = (r_state == StIdle) && i_start;

    assign w_off = r_addr[OFF_W-1:0];
    assign w_lsb = {w_off, 3'b000};

    // Lane merge; halfword offsets are even, so the 16-bit slice never runs off the word.
    always_comb begin
        w_merged = r_merge;
        if (r_size[0]) begin
            w_merged[w_lsb +: 16] = r_data[15:0];
        end else begin
            w_merged[w_lsb +: 8] = r_data[7:0];
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    if (w_reject) begin
                        w_state_next = StErr;
                    end else if (!i_store_size[1]) begin
                        w_state_next = StWrite;
                    end else begin
                        w_state_next = StRead;
                    end
                end
            end
            StRead:  if (i_mem_ready) w_state_next = StMerge;
            StMerge: w_state_next = StWrite;
            StWrite: if (i_mem_ready) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            StErr:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Request capture and merge register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr  <= '0;
            r_data  <= '0;
            r_size  <= '0;
            r_merge <= '0;
        end else begin
            if (w_accept) begin
                r_addr <= i_addr;
                r_data <= i_store_data;
                r_size <= i_store_size;
            end
            if (r_state == StRead && i_mem_ready) begin
                r_merge <= i_mem_rdata;
            end else if (r_state == StMerge) begin
                r_merge <= w_merged;
            end
        end
    end

    // Outputs decode the state register only: no path from i_mem_ready.
    always_comb begin
        o_mem_rd     = (r_state == StRead);
        o_mem_wr     = (r_state == StWrite);
        o_busy       = (r_state == StRead) || (r_state == StMerge) || (r_state == StWrite);
        o_done       = (r_state == StDone) || (r_state == StErr);
        o_misaligned = (r_state == StErr);
        o_mem_addr   = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        o_mem_wdata  = r_size[1] ? r_merge : r_data;
    end

endmodule

// File: tb/tb_store_rmw_unit.sv
module tb_store_rmw_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [1:0]  ssize;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        busy;
    logic        done;
    logic        mis;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rd_wait = 0;
    int wr_wait = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        bit mis;
        int cyc;
    } done_t;

    logic [31:0] exp_rd[$];
    wr_t         exp_wr[$];
    done_t       exp_done[$];

    store_rmw_unit #(
        .DATA_W(32),
        .ADDR_W(32)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_addr       (addr),
        .i_store_data (sdata),
        .i_store_size (ssize),
        .o_mem_addr   (mem_addr),
        .o_mem_rd     (mem_rd),
        .o_mem_wr     (mem_wr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata),
        .i_mem_ready  (mem_ready),
        .o_busy       (busy),
        .o_done       (done),
        .o_misaligned (mis)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    // Memory responder: inserts rd_wait / wr_wait not-ready cycles per request.
    initial begin
        int rd_cnt;
        int wr_cnt;
        rd_cnt = 0;
        wr_cnt = 0;
        mem_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (mem_rd) begin
                if (rd_cnt < rd_wait) begin
                    mem_ready = 1'b0;
                    rd_cnt++;
                end else begin
                    mem_ready = 1'b1;
                end
            end else if (mem_wr) begin
                if (wr_cnt < wr_wait) begin
                    mem_ready = 1'b0;
                    wr_cnt++;
                end else begin
                    mem_ready = 1'b1;
                end
            end else begin
                mem_ready = 1'b1;
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a request or completion.
    initial begin
        logic        p_pend;
        logic        p_rd;
        logic        p_wr;
        logic [31:0] p_addr;
        logic [31:0] p_wdata;
        logic [31:0] ra;
        wr_t         w;
        done_t       d;
        p_pend = 1'b0;
        p_rd = 1'b0;
        p_wr = 1'b0;
        p_addr = '0;
        p_wdata = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                p_pend = 1'b0;
            end else begin
                if (mem_rd && mem_wr) fail_now("rd_wr_overlap");
                if (mem_rd && exp_rd.size() == 0) fail_now("unexpected_rd");
                if (mem_wr && exp_wr.size() == 0) fail_now("unexpected_wr");
                if (p_pend) begin
                    check("hold_rd", 32'(mem_rd), 32'(p_rd));
                    check("hold_wr", 32'(mem_wr), 32'(p_wr));
                    check("hold_addr", mem_addr, p_addr);
                    check("hold_wdata", mem_wdata, p_wdata);
                end
                if (mem_rd && mem_ready && exp_rd.size() != 0) begin
                    ra = exp_rd.pop_front();
                    check("rd_addr", mem_addr, ra);
                end
                if (mem_wr && mem_ready && exp_wr.size() != 0) begin
                    w = exp_wr.pop_front();
                    check("wr_addr", mem_addr, w.addr);
                    check("wr_data", mem_wdata, w.data);
                end
                if (done) begin
                    if (exp_done.size() == 0) begin
                        fail_now("unexpected_done");
                    end else begin
                        d = exp_done.pop_front();
                        check("done_misaligned", 32'(mis), 32'(d.mis));
                        check("done_cycle", cyc, d.cyc);
                        check("busy_at_done", 32'(busy), 32'd0);
                    end
                end else if (mis) begin
                    fail_now("misaligned_without_done");
                end
                p_pend = (mem_rd || mem_wr) && !mem_ready;
                p_rd = mem_rd;
                p_wr = mem_wr;
                p_addr = mem_addr;
                p_wdata = mem_wdata;
            end
        end
    end

    // Drive one request and queue its hand-computed expectations.
    task automatic launch(input logic [31:0] a, input logic [31:0] dat, input logic [1:0] sz,
                          input logic [31:0] rdata, input int rw, input int ww,
                          input bit emis, input bit erd, input logic [31:0] ewd,
                          input int elat);
        @(negedge clk);
        addr = a;
        sdata = dat;
        ssize = sz;
        mem_rdata = rdata;
        rd_wait = rw;
        wr_wait = ww;
        start = 1'b1;
        if (erd) exp_rd.push_back(a & 32'hFFFF_FFFC);
        if (!emis) exp_wr.push_back('{a & 32'hFFFF_FFFC, ewd});
        exp_done.push_back('{emis, cyc + elat});
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), emis ? 32'd0 : 32'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            if (exp_done.size() == 0) break;
            @(negedge clk);
        end
        if (exp_done.size() != 0) begin
            fail_now("done_timeout");
            exp_done.delete();
            exp_rd.delete();
            exp_wr.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        addr = '0;
        sdata = '0;
        ssize = '0;
        mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_misaligned", 32'(mis), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        //     addr          data          size   rdata         rw ww mis rd  wdata         lat
        launch(32'h0000_1002, 32'h1234_5677, 2'b10, 32'hAABB_CCDD, 0, 0, 0, 1, 32'hAA77_CCDD, 4);
        wait_done();
        launch(32'h0000_2002, 32'h0000_BEEF, 2'b11, 32'h1122_3344, 0, 0, 0, 1, 32'hBEEF_3344, 4);
        wait_done();
        launch(32'h0000_3000, 32'hCAFE_F00D, 2'b00, 32'h0,         0, 0, 0, 0, 32'hCAFE_F00D, 2);
        wait_done();
        launch(32'h0000_1001, 32'h0000_1234, 2'b11, 32'h0,         0, 0, 1, 0, 32'h0,         1);
        wait_done();
        launch(32'h0000_1002, 32'h1111_2222, 2'b00, 32'h0,         0, 0, 1, 0, 32'h0,         1);
        wait_done();
        launch(32'h0000_1003, 32'h0000_5678, 2'b11, 32'h0,         0, 0, 1, 0, 32'h0,         1);
        wait_done();
        launch(32'h0000_1001, 32'h3333_4444, 2'b01, 32'h0,         0, 0, 1, 0, 32'h0,         1);
        wait_done();
        launch(32'h0000_4000, 32'h0000_00A5, 2'b10, 32'h1122_3344, 0, 0, 0, 1, 32'h1122_33A5, 4);
        wait_done();
        launch(32'h0000_4003, 32'h0000_005A, 2'b10, 32'h1122_3344, 0, 0, 0, 1, 32'h5A22_3344, 4);
        wait_done();
        launch(32'h0000_4001, 32'hFFFF_FFFF, 2'b10, 32'h0000_0000, 0, 0, 0, 1, 32'h0000_FF00, 4);
        wait_done();
        launch(32'h0000_5000, 32'h1234_ABCD, 2'b11, 32'hFFFF_FFFF, 0, 0, 0, 1, 32'hFFFF_ABCD, 4);
        wait_done();
        launch(32'hFFFF_FFFE, 32'h0000_0099, 2'b10, 32'h0102_0304, 0, 0, 0, 1, 32'h0199_0304, 4);
        wait_done();
        // Wait states: 3 in READ, 2 in WRITE -> 5 cycles beyond zero-wait.
        launch(32'h0000_1002, 32'h1234_5677, 2'b10, 32'hAABB_CCDD, 3, 2, 0, 1, 32'hAA77_CCDD, 9);
        wait_done();
        launch(32'h0000_6004, 32'h0102_0304, 2'b00, 32'h0,         0, 1, 0, 0, 32'h0102_0304, 3);
        wait_done();

        // Reset during WRITE drops the request and yields no done.
        @(negedge clk);
        rd_wait = 0;
        wr_wait = 20;
        mem_rdata = 32'h0;
        addr = 32'h0000_7001;
        sdata = 32'h0000_0033;
        ssize = 2'b10;
        start = 1'b1;
        exp_rd.push_back(32'h0000_7000);
        exp_wr.push_back('{32'h0000_7000, 32'h0000_3300});
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10 && !mem_wr; i++) @(negedge clk);
        check("abort_reach_write", 32'(mem_wr), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_wr_drop", 32'(mem_wr), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_mem_addr", mem_addr, 32'd0);
        exp_wr.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        launch(32'h0000_7001, 32'h0000_0033, 2'b10, 32'h4444_4444, 0, 0, 0, 1, 32'h4444_3344, 4);
        wait_done();

        // start while busy is ignored.
        launch(32'h0000_8002, 32'h0000_0011, 2'b10, 32'h0000_0000, 2, 0, 0, 1, 32'h0011_0000, 6);
        addr = 32'h0000_9000;
        sdata = 32'hDEAD_BEEF;
        ssize = 2'b00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // start coincident with DONE is ignored.
        launch(32'h0000_A000, 32'h5555_AAAA, 2'b00, 32'h0,         0, 0, 0, 0, 32'h5555_AAAA, 2);
        @(negedge clk);
        addr = 32'h0000_B000;
        sdata = 32'h0BAD_0BAD;
        ssize = 2'b00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (6) @(negedge clk);

        check("rd_queue_empty", exp_rd.size(), 32'd0);
        check("wr_queue_empty", exp_wr.size(), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
